// File: rtl/debounce_pkg.sv
// debounce_pkg
// Shared types and helpers for the debouncer bank.
//   hold_state_t : per-channel long-press FSM states (IDLE, COUNT, REPEAT)
//   cnt_width()  : bits needed to hold a given maximum counter value (min 1)

package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        REPEAT = 2'd2
    } hold_state_t;

    // Width of a counter that must represent 0..max_val; never less than one
    // bit so that a terminal count of zero still yields a legal vector.
    function automatic int cnt_width(input int max_val);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((max_val >>> i) != 0) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/debouncer_bank_if.sv
// debouncer_bank_if
// Bundles the per-channel button vectors of the debouncer bank.
//   raw_i     : raw asynchronous button inputs
//   level_o   : debounced pressed level
//   press_o   : one-cycle pulse on accepted press
//   release_o : one-cycle pulse on accepted release
//   hold_o    : one-cycle pulse after a long press
//   repeat_o  : one-cycle auto-repeat pulses following hold_o
// master = the side that owns the buttons, slave = the debouncer bank.

interface debouncer_bank_if #(
    parameter int N_CH = 4
);
    logic [N_CH-1:0] raw_i;
    logic [N_CH-1:0] level_o;
    logic [N_CH-1:0] press_o;
    logic [N_CH-1:0] release_o;
    logic [N_CH-1:0] hold_o;
    logic [N_CH-1:0] repeat_o;

    modport master (
        output raw_i,
        input  level_o,
        input  press_o,
        input  release_o,
        input  hold_o,
        input  repeat_o
    );

    modport slave (
        input  raw_i,
        output level_o,
        output press_o,
        output release_o,
        output hold_o,
        output repeat_o
    );
endinterface

// File: rtl/debounce_channel.sv
// debounce_channel
// One button channel: 2-flop synchroniser, polarity correction, consecutive
// sample debounce, and long-press hold / auto-repeat FSM.
//   clk, rst  : system clock, asynchronous active-high reset
//   raw_i     : raw asynchronous button input
//   level_o   : debounced pressed level (1 = pressed)
//   press_o   : pulse in the cycle the level rises
//   release_o : pulse in the cycle the level falls
//   hold_o    : pulse HOLD_CYCLES after the press was accepted
//   repeat_o  : pulse every REPEAT_CYCLES after hold_o (0 disables)

module debounce_channel
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 15000,
    parameter int HOLD_CYCLES     = 500000,
    parameter int REPEAT_CYCLES   = 100000,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic hold_o,
    output logic repeat_o
);

    localparam int DCNT_W   = cnt_width(DEBOUNCE_CYCLES - 1);
    // hcnt can park one past the terminal count when repeat is disabled
    localparam int HCNT_W   = cnt_width(HOLD_CYCLES);
    localparam int REP_LAST = (REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0;
    localparam int RCNT_W   = cnt_width(REP_LAST);

    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(HOLD_CYCLES - 1);
    localparam logic [HCNT_W-1:0] HCNT_SAT  = HCNT_W'(HOLD_CYCLES);
    localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(REP_LAST);

    logic              sync1_r;
    logic              sync2_r;
    logic              sample_s;
    logic              level_r;
    logic [DCNT_W-1:0] dcnt_r;
    logic              press_r;
    logic              release_r;
    logic              flip_s;
    logic              rise_s;
    logic              fall_s;

    hold_state_t       state_r;
    hold_state_t       state_s;
    logic [HCNT_W-1:0] hcnt_r;
    logic [HCNT_W-1:0] hcnt_s;
    logic [RCNT_W-1:0] rcnt_r;
    logic [RCNT_W-1:0] rcnt_s;
    logic              hold_r;
    logic              hold_s;
    logic              repeat_r;
    logic              repeat_s;

    // Two-flop synchroniser for the asynchronous button input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= raw_i;
            sync2_r <= sync1_r;
        end
    end

    assign sample_s = sync2_r ^ ACTIVE_LOW;

    // The level flips on the edge that sees the last required differing sample.
    assign flip_s = (sample_s != level_r) && (dcnt_r == DCNT_LAST);
    assign rise_s = flip_s && sample_s;
    assign fall_s = flip_s && !sample_s;

    // Debounce counter and accepted level; any agreeing sample restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_r <= 1'b0;
            dcnt_r  <= '0;
        end else if (sample_s == level_r) begin
            dcnt_r  <= '0;
        end else if (dcnt_r == DCNT_LAST) begin
            level_r <= sample_s;
            dcnt_r  <= '0;
        end else begin
            dcnt_r  <= dcnt_r + DCNT_W'(1);
        end
    end

    // Press/release pulses register alongside the level flip.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            press_r   <= 1'b0;
            release_r <= 1'b0;
        end else begin
            press_r   <= rise_s;
            release_r <= fall_s;
        end
    end

    // Hold FSM state, counters and registered hold/repeat pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            hcnt_r   <= '0;
            rcnt_r   <= '0;
            hold_r   <= 1'b0;
            repeat_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            hcnt_r   <= hcnt_s;
            rcnt_r   <= rcnt_s;
            hold_r   <= hold_s;
            repeat_r <= repeat_s;
        end
    end

    // Hold FSM next state; a falling level overrides everything so a release
    // on the same edge as a hold/repeat suppresses that pulse.
    always_comb begin
        state_s  = state_r;
        hcnt_s   = hcnt_r;
        rcnt_s   = rcnt_r;
        hold_s   = 1'b0;
        repeat_s = 1'b0;
        if (fall_s) begin
            state_s = IDLE;
            hcnt_s  = '0;
            rcnt_s  = '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (rise_s) begin
                        state_s = COUNT;
                        hcnt_s  = '0;
                    end else begin
                        state_s = IDLE;
                    end
                end
                COUNT: begin
                    if (hcnt_r == HCNT_LAST) begin
                        hold_s = 1'b1;
                        if (REPEAT_CYCLES > 0) begin
                            state_s = REPEAT;
                            rcnt_s  = '0;
                        end else begin
                            hcnt_s  = HCNT_SAT;
                        end
                    end else if (hcnt_r < HCNT_LAST) begin
                        hcnt_s = hcnt_r + HCNT_W'(1);
                    end else begin
                        hcnt_s = hcnt_r;
                    end
                end
                REPEAT: begin
                    if (rcnt_r == RCNT_LAST) begin
                        repeat_s = 1'b1;
                        rcnt_s   = '0;
                    end else begin
                        rcnt_s   = rcnt_r + RCNT_W'(1);
                    end
                end
                default: begin
                    state_s = IDLE;
                    hcnt_s  = '0;
                    rcnt_s  = '0;
                end
            endcase
        end
    end

    assign level_o   = level_r;
    assign press_o   = press_r;
    assign release_o = release_r;
    assign hold_o    = hold_r;
    assign repeat_o  = repeat_r;

endmodule

// File: rtl/debouncer_bank.sv
// debouncer_bank
// N_CH independent button channels; the top only fans the interface vectors
// out to one debounce_channel per bit.
//   clk, rst : system clock, asynchronous active-high reset
//   bus      : debouncer_bank_if slave (raw_i in; level/press/release/
//              hold/repeat vectors out)

module debouncer_bank #(
    parameter int              N_CH            = 4,
    parameter int              DEBOUNCE_CYCLES = 15000,
    parameter int              HOLD_CYCLES     = 500000,
    parameter int              REPEAT_CYCLES   = 100000,
    parameter logic [N_CH-1:0] ACTIVE_LOW      = '0
) (
    input  logic           clk,
    input  logic           rst,
    debouncer_bank_if.slave bus
);

    logic [N_CH-1:0] level_s;
    logic [N_CH-1:0] press_s;
    logic [N_CH-1:0] release_s;
    logic [N_CH-1:0] hold_s;
    logic [N_CH-1:0] repeat_s;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW[i])
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .raw_i     (bus.raw_i[i]),
            .level_o   (level_s[i]),
            .press_o   (press_s[i]),
            .release_o (release_s[i]),
            .hold_o    (hold_s[i]),
            .repeat_o  (repeat_s[i])
        );
    end

    assign bus.level_o   = level_s;
    assign bus.press_o   = press_s;
    assign bus.release_o = release_s;
    assign bus.hold_o    = hold_s;
    assign bus.repeat_o  = repeat_s;

endmodule
